// File: rtl/pr_bridge_multi.sv
// Peripheral bridge: decodes NUM_DEV device windows, issues write strobes / registered reads
// and aggregates device interrupts into HWInt. Optional macro PR_IRQ_LATCH_EN latches IRQ edges.
module pr_bridge_multi #(
    parameter int unsigned NUM_DEV    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter logic [31:0] DEV_SPAN   = 32'hC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pr_addr,
    input  logic [31:0]             pr_wd,
    input  logic                    pr_we,
    input  logic                    pr_re,
    output logic [31:0]             pr_rd,
    output logic                    pr_ready,
    output logic                    pr_err,
    output logic [31:0]             dev_addr,
    output logic [31:0]             dev_wd,
    output logic [NUM_DEV-1:0]      dev_we,
    input  logic [32*NUM_DEV-1:0]   dev_rd,
    input  logic [NUM_DEV-1:0]      dev_irq,
    output logic [5:0]              hwint
);

    localparam int unsigned STRIDE_LOG2 = $clog2(DEV_STRIDE);
    localparam int unsigned IDX_W       = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               hit_q, hit_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        dev_addr_q, dev_addr_d;
    logic [31:0]        dev_wd_q, dev_wd_d;
    logic [NUM_DEV-1:0] dev_we_q, dev_we_d;
    logic [31:0]        pr_rd_q, pr_rd_d;
    logic               pr_ready_q, pr_ready_d;
    logic               pr_err_q, pr_err_d;
    logic [5:0]         hwint_q, hwint_d;

    logic [31:0]        off;
    logic [31:0]        idx_full;
    logic               req_hit;
    logic [31:0]        sel_rd;

    // Window decode; unsigned subtraction wrap below BASE_ADDR is masked by the >= test
    always_comb begin
        off      = pr_addr - BASE_ADDR;
        idx_full = off >> STRIDE_LOG2;
        req_hit  = (pr_addr >= BASE_ADDR) &&
                   (idx_full < 32'(NUM_DEV)) &&
                   ((off & (DEV_STRIDE - 32'd1)) < DEV_SPAN) &&
                   (pr_addr[1:0] == 2'b00);
    end

    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if (idx_q == IDX_W'(i)) sel_rd = dev_rd[32*i +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        dev_addr_d = dev_addr_q;
        dev_wd_d   = dev_wd_q;
        dev_we_d   = '0;
        pr_rd_d    = '0;
        pr_ready_d = 1'b0;
        pr_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pr_we || pr_re) begin
                    dev_addr_d = pr_addr;
                    dev_wd_d   = pr_wd;
                    wr_d       = pr_we;
                    hit_d      = req_hit;
                    idx_d      = IDX_W'(idx_full);
                    if (pr_we && req_hit) begin
                        for (int i = 0; i < int'(NUM_DEV); i++) begin
                            dev_we_d[i] = (idx_full == 32'(i));
                        end
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                pr_ready_d = 1'b1;
                pr_err_d   = ~hit_q;
                if (hit_q && !wr_q) pr_rd_d = sel_rd;
                state_d    = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef PR_IRQ_LATCH_EN
    logic [NUM_DEV-1:0] irq_prev_q;
    logic [NUM_DEV-1:0] pending_q, pending_d;

    // Rising edge sets, a completed write strobe clears; set wins on collision
    always_comb begin
        pending_d = (pending_q & ~dev_we_q) | (dev_irq & ~irq_prev_q);
        hwint_d   = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) hwint_d[i] = pending_d[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= dev_irq;
            pending_q  <= pending_d;
        end
    end
`else
    always_comb begin
        hwint_d = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) hwint_d[i] = dev_irq[i];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hit_q      <= 1'b0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            dev_addr_q <= '0;
            dev_wd_q   <= '0;
            dev_we_q   <= '0;
            pr_rd_q    <= '0;
            pr_ready_q <= 1'b0;
            pr_err_q   <= 1'b0;
            hwint_q    <= '0;
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            dev_addr_q <= dev_addr_d;
            dev_wd_q   <= dev_wd_d;
            dev_we_q   <= dev_we_d;
            pr_rd_q    <= pr_rd_d;
            pr_ready_q <= pr_ready_d;
            pr_err_q   <= pr_err_d;
            hwint_q    <= hwint_d;
        end
    end

    assign pr_rd    = pr_rd_q;
    assign pr_ready = pr_ready_q;
    assign pr_err   = pr_err_q;
    assign dev_addr = dev_addr_q;
    assign dev_wd   = dev_wd_q;
    assign dev_we   = dev_we_q;
    assign hwint    = hwint_q;

endmodule

// File: tb/tb_pr_bridge_multi.sv
// Scoreboard bench for pr_bridge_multi (two devices, default windows).
module tb_pr_bridge_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pr_addr, pr_wd;
    logic        pr_we, pr_re;
    logic [31:0] pr_rd;
    logic        pr_ready, pr_err;
    logic [31:0] dev_addr, dev_wd;
    logic [1:0]  dev_we;
    logic [63:0] dev_rd;
    logic [1:0]  dev_irq;
    logic [5:0]  hwint;

    pr_bridge_multi dut (
        .clk(clk), .reset(reset),
        .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .pr_re(pr_re),
        .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we),
        .dev_rd(dev_rd), .dev_irq(dev_irq), .hwint(hwint)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  we;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } txn_t;

    txn_t sb_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic strobe_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobes and responses are matched against the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (dev_we != 2'b00) begin
                if (sb_q.size() == 0) check("unexp_strobe", 32'(dev_we), 32'd0);
                else begin
                    check("dev_we", 32'(dev_we), 32'(sb_q[0].we));
                    check("dev_addr", dev_addr, sb_q[0].addr);
                    check("dev_wd", dev_wd, sb_q[0].wd);
                    check("strobe_lat", 32'(cyc), 32'(sb_q[0].cyc + 1));
                    strobe_seen = 1'b1;
                end
            end
            if (pr_ready) begin
                if (sb_q.size() == 0) check("unexp_ready", 32'd1, 32'd0);
                else begin
                    txn_t t;
                    t = sb_q.pop_front();
                    check("pr_rd", pr_rd, t.rd);
                    check("pr_err", 32'(pr_err), 32'(t.err));
                    check("ready_lat", 32'(cyc), 32'(t.cyc + 2));
                    check("strobe_seen", 32'(strobe_seen), 32'(t.we != 2'b00));
                    strobe_seen = 1'b0;
                end
            end
        end
    end

    task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                          input logic re, input logic [1:0] exp_we, input logic [31:0] exp_rd,
                          input logic exp_err);
        bit got = 0;
        @(negedge clk);
        pr_addr = addr; pr_wd = wd; pr_we = we; pr_re = re;
        sb_q.push_back('{addr, wd, exp_we, exp_rd, exp_err, cyc});
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (pr_ready) got = 1;
        end
        if (!got) check("timeout", 32'd0, 32'd1);
        pr_we = 1'b0; pr_re = 1'b0;
    endtask

    // Request held across RESP must be re-accepted in the following IDLE cycle
    task automatic back_to_back(input logic [31:0] addr, input logic [31:0] exp_rd);
        int readies = 0;
        @(negedge clk);
        pr_addr = addr; pr_wd = 32'd0; pr_we = 1'b0; pr_re = 1'b1;
        sb_q.push_back('{addr, 32'd0, 2'b00, exp_rd, 1'b0, cyc});
        sb_q.push_back('{addr, 32'd0, 2'b00, exp_rd, 1'b0, cyc + 3});
        for (int i = 0; i < 12 && readies < 2; i++) begin
            @(negedge clk);
            if (pr_ready) readies++;
        end
        check("b2b_count", 32'(readies), 32'd2);
        pr_re = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, pr_rd, 32'd0);
        check({tag, "_ready"}, 32'(pr_ready), 32'd0);
        check({tag, "_err"}, 32'(pr_err), 32'd0);
        check({tag, "_addr"}, dev_addr, 32'd0);
        check({tag, "_wd"}, dev_wd, 32'd0);
        check({tag, "_we"}, 32'(dev_we), 32'd0);
        check({tag, "_hwint"}, 32'(hwint), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        pr_addr = '0; pr_wd = '0; pr_we = 1'b0; pr_re = 1'b0;
        dev_rd = {32'hDEAD_BEEF, 32'h1234_5678};
        dev_irq = 2'b00;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        access(32'h0000_7F04, 32'h0000_0009, 1'b1, 1'b0, 2'b01, 32'd0, 1'b0);
        access(32'h0000_7F18, 32'h0,         1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0);
        access(32'h0000_7F0C, 32'h0,         1'b0, 1'b1, 2'b00, 32'd0, 1'b1);
        access(32'h0000_7F20, 32'h0,         1'b0, 1'b1, 2'b00, 32'd0, 1'b1);
        access(32'h0000_7EFC, 32'h0,         1'b0, 1'b1, 2'b00, 32'd0, 1'b1);
        access(32'h0000_7F01, 32'h0,         1'b0, 1'b1, 2'b00, 32'd0, 1'b1);
        access(32'h0000_7F10, 32'h0000_00A5, 1'b1, 1'b1, 2'b10, 32'd0, 1'b0);
        access(32'h0000_7F00, 32'h0,         1'b0, 1'b1, 2'b00, 32'h1234_5678, 1'b0);
        access(32'h0000_7F08, 32'hFFFF_0000, 1'b1, 1'b0, 2'b01, 32'd0, 1'b0);
        access(32'h0000_7F1C, 32'h0000_0077, 1'b1, 1'b0, 2'b00, 32'd0, 1'b1);
        access(32'h0000_0000, 32'h0,         1'b0, 1'b1, 2'b00, 32'd0, 1'b1);
        access(32'hFFFF_FF00, 32'h0,         1'b0, 1'b1, 2'b00, 32'd0, 1'b1);
        access(32'h0000_7F12, 32'h0000_0001, 1'b1, 1'b0, 2'b00, 32'd0, 1'b1);
        back_to_back(32'h0000_7F14, 32'hDEAD_BEEF);

        // Reset during the ACCESS cycle of a write aborts it
        @(negedge clk);
        pr_addr = 32'h0000_7F10; pr_wd = 32'h0000_0055; pr_we = 1'b1;
        @(posedge clk);
        #2;
        check("pre_abort_we", 32'(dev_we), 32'h2);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        pr_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_ready", 32'(pr_ready), 32'd0);

        // Interrupt aggregation
        check("irq_idle", 32'(hwint), 32'd0);
        @(negedge clk);
        dev_irq = 2'b10;
        @(posedge clk);
        #1;
        check("irq_rise", 32'(hwint), 32'h02);
        @(negedge clk);
        dev_irq = 2'b00;
        @(posedge clk);
        #1;
`ifdef PR_IRQ_LATCH_EN
        check("irq_held", 32'(hwint), 32'h02);
`else
        check("irq_drop", 32'(hwint), 32'h00);
`endif
        access(32'h0000_7F10, 32'h0000_0001, 1'b1, 1'b0, 2'b10, 32'd0, 1'b0);
        check("irq_after_wr", 32'(hwint), 32'h00);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pr_bridge_multi.md
Name: pr_bridge_multi

Overview:
Parametrised system bridge between the CPU's peripheral port and NUM_DEV memory-mapped devices placed at a fixed address stride. Decodes the device window, issues a single-cycle write strobe or a registered read, and returns data with a ready/error handshake. Also aggregates device interrupt lines into the 6-bit HWInt vector sent to the CP0. Sits between the CPU data-memory port and the timer/peripheral devices.

Parameters:
NUM_DEV, 2, number of device windows (1..6)
BASE_ADDR, 32'h0000_7F00, byte address of device 0 window
DEV_STRIDE, 32'h10, byte distance between windows (power of two)
DEV_SPAN, 32'hC, valid bytes per window, starting at window base (SPAN <= STRIDE)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pr_addr  in  32  CPU byte address
pr_wd  in  32  CPU write data
pr_we  in  1  write request
pr_re  in  1  read request
pr_rd  out  32  read data, valid while pr_ready=1
pr_ready  out  1  one-cycle completion pulse
pr_err  out  1  unmapped/unaligned access, valid with pr_ready
dev_addr  out  32  registered address to devices
dev_wd  out  32  registered write data to devices
dev_we  out  NUM_DEV  one-hot write strobe
dev_rd  in  32*NUM_DEV  flattened device read data, device i at [32i+31:32i]
dev_irq  in  NUM_DEV  level interrupt request per device
hwint  out  6  to CP0; bits >= NUM_DEV tied 0

Behaviour:
- Reset (async, active-high): state=IDLE; pr_rd=0, pr_ready=0, pr_err=0, dev_addr=0, dev_wd=0, dev_we=0, hwint=0, pending=0.
- Decode: off=pr_addr-BASE_ADDR; idx=off/DEV_STRIDE; hit iff pr_addr>=BASE_ADDR, idx<NUM_DEV, (off%DEV_STRIDE)<DEV_SPAN, pr_addr[1:0]==0.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: if pr_we|pr_re, latch addr, wd, write flag (pr_we has priority when both are set), hit and idx; go to ACCESS. Otherwise stay.
- ACCESS (1 cycle): dev_addr/dev_wd hold the latched values. For a write hit, dev_we[idx]=1 for exactly this cycle; all other bits stay 0. For a read hit, capture dev_rd[idx] into the read register at the clock edge ending the cycle. On a miss, no strobe is issued and the read register gets 0. Go to RESP.
- RESP (1 cycle): pr_ready=1. pr_rd=captured data for reads; 0 for writes and misses. pr_err=~hit. Go to IDLE.
- Latency: request sampled at edge 0, strobe during cycle 1, pr_ready during cycle 2. Throughput: one access per 3 cycles.
- The CPU holds its request until pr_ready. Request inputs are ignored outside IDLE. A request still asserted in the cycle after RESP starts a new access.
- dev_addr/dev_wd hold their last value outside ACCESS; dev_we=0 outside ACCESS.
- hwint[i] = dev_irq[i] registered by one flop (i<NUM_DEV), unless PR_IRQ_LATCH_EN is set.
- Reset asserted mid-access: the access is aborted immediately and no strobe completes. The CPU sees no pr_ready for it.
- Address arithmetic is unsigned 32-bit. An address below BASE_ADDR is a miss, with no wrap.

Optional Feature:
PR_IRQ_LATCH_EN
- Defined: per-device pending bit, set on a rising edge of dev_irq[i] (previous sample 0, current 1). Cleared when a write hit to device i completes its ACCESS cycle; if a set and a clear occur in the same cycle, set wins. hwint[i]=pending[i].
- Undefined: no pending state; hwint[i] is the registered dev_irq[i], as stated in Behaviour.

Test Plan:
- Write 0x0000_0009 to 0x7F04 -> dev_we=2'b01 for one cycle with dev_addr=0x7F04 and dev_wd=9; pr_ready two cycles after request; pr_err=0.
- Read 0x7F18 with dev_rd[63:32]=0xDEAD_BEEF -> dev_we stays 0; pr_ready pulse with pr_rd=0xDEAD_BEEF and pr_err=0.
- Read 0x7F0C (beyond span), 0x7F20 (idx=2), 0x7EFC and 0x7F01 (unaligned) -> no strobe; pr_rd=0, pr_err=1.
- pr_we and pr_re both high at 0x7F10 -> treated as a write: dev_we=2'b10, pr_rd=0.
- Assert reset during the ACCESS cycle of a write -> dev_we drops to 0 immediately; no pr_ready; all outputs at reset values.
- dev_irq=2'b10 rising -> hwint=6'b000010 one cycle later. With PR_IRQ_LATCH_EN: drop dev_irq, hwint stays 6'b000010 until a write to 0x7F10 completes, then returns to 0.
